// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: Moore decode of the state register into datapath strobes.
// Optional bne support is enabled by defining MULTICYCLE_CONTROL_BNE_EN.
module multicycle_control #(
    parameter logic [3:0] ALU_ADD = 4'b0010,
    parameter logic [3:0] ALU_SUB = 4'b0110,
    parameter logic [3:0] ALU_AND = 4'b0000,
    parameter logic [3:0] ALU_OR  = 4'b0001,
    parameter logic [3:0] ALU_SLT = 4'b0111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       PCSrc,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEMADR   = 4'd3;
    localparam logic [3:0] S_MEMREAD  = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_MEMWRITE = 4'd6;
    localparam logic [3:0] S_EXECUTE  = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_ADDIEXEC = 4'd10;
    localparam logic [3:0] S_ADDIWB   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

`ifdef MULTICYCLE_CONTROL_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       funct_ok;
    logic [3:0] funct_alu;
    logic       is_bne;
    logic       instr_ok;

    // R-type function decode into ALU operation
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 4'b0000;
        case (Funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    assign is_bne   = BNE_EN && (Op == OP_BNE);
    assign instr_ok = ((Op == OP_RTYPE) && funct_ok) || (Op == OP_LW) || (Op == OP_SW)
                    || (Op == OP_BEQ) || (Op == OP_ADDI) || is_bne;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and Moore output decode; unlisted outputs stay 0
    always_comb begin
        state_nxt  = S_FETCH;
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        PCSrc      = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 4'b0000;
        illegal_o  = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                state_nxt  = S_DECODE;
                IRWrite    = 1'b1;
                PCWrite    = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = ALU_ADD;
                illegal_o  = !instr_ok;
                if (instr_ok) begin
                    case (Op)
                        OP_RTYPE:      state_nxt = S_EXECUTE;
                        OP_LW, OP_SW:  state_nxt = S_MEMADR;
                        OP_BEQ,OP_BNE: state_nxt = S_BRANCH;
                        OP_ADDI:       state_nxt = S_ADDIEXEC;
                        default:       state_nxt = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                state_nxt  = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
            end
            S_ADDIEXEC: begin
                state_nxt  = S_ADDIWB;
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
            end
            S_MEMREAD: begin
                state_nxt = S_MEMWB;
                IorD      = 1'b1;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_EXECUTE: begin
                state_nxt  = S_ALUWB;
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 1'b1;
                PCWrite    = (Op == OP_BEQ) ? Zero : (is_bne ? ~Zero : 1'b0);
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    assign state_o = state;

endmodule
